proc_control: RTL and testbench

Instruction control unit for the basic 16-bit processor. Holds the 9-bit instruction register and sequences each instruction through states T0–T3. In every cycle it drives the one-hot `select` code for the bus multiplexer and the load enables for R0–R7, A, G and IR. It sits directly upstream of the bus mux and alongside the register file and adder/subtractor.

---
 rtl/proc_pkg.sv | 26 ++
 rtl/proc_control_dec3to8.sv | 16 +
 rtl/proc_control.sv | 155 +++++++++++++++
 tb/tb_proc_control.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared constants for the 16-bit processor: opcodes, control states, bus mux bit map.
package proc_pkg;

    // Instruction opcodes held in IR[8:6]
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam int unsigned IR_W  = 9;
    localparam int unsigned SEL_W = 10;

    // Bus mux select bit positions; Rn sits at SEL_R0 - n
    localparam int unsigned SEL_DIN = 0;
    localparam int unsigned SEL_G   = 1;
    localparam int unsigned SEL_R0  = 9;

    // Instruction timing states
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage

// File: rtl/proc_control_dec3to8.sv
// 3-bit to one-hot-8 decoder with enable.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] code,
    output logic [7:0] onehot
);

    // Single hot bit when enabled, all zero otherwise
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[code] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control.sv
// Instruction control unit: IR, T0-T3 sequencer, bus select and load enables.
module proc_control
    import proc_pkg::*;
#(
    parameter int unsigned WORD = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [WORD-1:0] din,
    output logic            ir_in,
    output logic [7:0]      r_in,
    output logic            a_in,
    output logic            g_in,
    output logic            add_sub,
    output logic [SEL_W-1:0] select,
    output logic            done
);

    state_t          state;
    state_t          state_nxt;
    logic [IR_W-1:0] ir;

    logic            r_en;
    logic            sel_din;
    logic            sel_g;
    logic            sel_reg_en;
    logic [2:0]      sel_field;
    logic [7:0]      reg_hot;

    // Upper din bits carry only the mvi immediate, consumed by the datapath
    logic unused_din;
    assign unused_din = ^din[WORD-1:IR_W];

    wire [2:0] opcode = ir[8:6];
    wire [2:0] rx     = ir[5:3];
    wire [2:0] ry     = ir[2:0];

    // State and instruction register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (ir_in) begin
                ir <= din[IR_W-1:0];
            end
        end
    end

    // Next state and control strobes; everything held low during reset
    always_comb begin
        state_nxt  = state;
        ir_in      = 1'b0;
        r_en       = 1'b0;
        a_in       = 1'b0;
        g_in       = 1'b0;
        add_sub    = 1'b0;
        sel_din    = 1'b0;
        sel_g      = 1'b0;
        sel_reg_en = 1'b0;
        sel_field  = ry;
        done       = 1'b0;

        case (state)
            T0: begin
                if (run) begin
                    ir_in     = 1'b1;
                    state_nxt = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        sel_reg_en = 1'b1;
                        sel_field  = ry;
                        r_en       = 1'b1;
                        done       = 1'b1;
                        state_nxt  = T0;
                    end
                    OP_MVI: begin
                        sel_din   = 1'b1;
                        r_en      = 1'b1;
                        done      = 1'b1;
                        state_nxt = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        sel_reg_en = 1'b1;
                        sel_field  = rx;
                        a_in       = 1'b1;
                        state_nxt  = T2;
                    end
                    default: begin
                        done      = 1'b1;
                        state_nxt = T0;
                    end
                endcase
            end
            T2: begin
                sel_reg_en = 1'b1;
                sel_field  = ry;
                g_in       = 1'b1;
                add_sub    = ir[6];
                state_nxt  = T3;
            end
            T3: begin
                sel_g     = 1'b1;
                r_en      = 1'b1;
                done      = 1'b1;
                state_nxt = T0;
            end
            default: begin
                state_nxt = T0;
            end
        endcase

        if (reset) begin
            ir_in      = 1'b0;
            r_en       = 1'b0;
            a_in       = 1'b0;
            g_in       = 1'b0;
            add_sub    = 1'b0;
            sel_din    = 1'b0;
            sel_g      = 1'b0;
            sel_reg_en = 1'b0;
            done       = 1'b0;
        end
    end

    // Destination register load enable
    dec3to8 u_dec_rin (
        .en     (r_en),
        .code   (rx),
        .onehot (r_in)
    );

    // Register source for the bus
    dec3to8 u_dec_sel (
        .en     (sel_reg_en),
        .code   (sel_field),
        .onehot (reg_hot)
    );

    // Bus mux code; register bits are reversed so R0 lands at the top
    always_comb begin
        select          = '0;
        select[SEL_DIN] = sel_din;
        select[SEL_G]   = sel_g;
        for (int unsigned n = 0; n < 8; n++) begin
            select[4'(SEL_R0 - n)] = reg_hot[3'(n)];
        end
    end

endmodule

// File: tb/tb_proc_control.sv
// Directed self-checking bench for proc_control.
module tb_proc_control;
    import proc_pkg::*;

    logic        clk;
    logic        reset;
    logic        run;
    logic [15:0] din;
    logic        ir_in;
    logic [7:0]  r_in;
    logic        a_in;
    logic        g_in;
    logic        add_sub;
    logic [9:0]  select;
    logic        done;

    int checks = 0;
    int errors = 0;

    proc_control #(.WORD(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .din     (din),
        .ir_in   (ir_in),
        .r_in    (r_in),
        .a_in    (a_in),
        .g_in    (g_in),
        .add_sub (add_sub),
        .select  (select),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs as one vector {ir_in, r_in, a_in, g_in, add_sub, select, done}
    task automatic chk(input string tag, input logic e_ir, input logic [7:0] e_r,
                       input logic e_a, input logic e_g, input logic e_as,
                       input logic [9:0] e_sel, input logic e_done);
        logic [22:0] obs;
        logic [22:0] exp;
        #1;
        obs = {ir_in, r_in, a_in, g_in, add_sub, select, done};
        exp = {e_ir, e_r, e_a, e_g, e_as, e_sel, e_done};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input state_t e_st, input logic [8:0] e_ir);
        checks++;
        assert (dut.state === e_st) else begin
            errors++;
            $error("FAIL %s_state: observed %0d expected %0d", tag, dut.state, e_st);
        end
        checks++;
        assert (dut.ir === e_ir) else begin
            errors++;
            $error("FAIL %s_ir: observed %h expected %h", tag, dut.ir, e_ir);
        end
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        din   = '0;
        #1;
        chk("reset_active", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'b0, 1'b0);
        tick();
        reset = 1'b0;

        // Idle in T0
        for (int i = 0; i < 5; i++) begin
            chk("idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'b0, 1'b0);
            chk_state("idle", T0, 9'h000);
            tick();
        end

        // mvi R3,#A5
        run = 1'b1;
        din = 16'(9'b001_011_000);
        chk("mvi_t0", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 10'b0, 1'b0);
        tick();
        run = 1'b0;
        din = 16'h00A5;
        chk("mvi_t1", 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 10'b00_0000_0001, 1'b1);
        tick();
        chk("mvi_after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'b0, 1'b0);
        chk_state("mvi_after", T0, 9'b001_011_000);

        // mv R1,R6
        run = 1'b1;
        din = 16'(9'b000_001_110);
        tick();
        run = 1'b0;
        din = '0;
        chk("mv_t1", 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 10'b00_0000_1000, 1'b1);
        tick();

        // sub R0,R7
        run = 1'b1;
        din = 16'(9'b011_000_111);
        tick();
        run = 1'b0;
        din = '0;
        chk("sub_t1", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 10'b10_0000_0000, 1'b0);
        tick();
        chk("sub_t2", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 10'b00_0000_0100, 1'b0);
        tick();
        chk("sub_t3", 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 10'b00_0000_0010, 1'b1);
        tick();
        chk_state("sub_after", T0, 9'b011_000_111);

        // add R3,R3 with run held, reset in T2
        run = 1'b1;
        din = 16'(9'b010_011_011);
        chk("add_t0", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 10'b0, 1'b0);
        tick();
        chk("add_t1", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 10'b00_0100_0000, 1'b0);
        tick();
        reset = 1'b1;
        chk("add_t2_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'b0, 1'b0);
        tick();
        reset = 1'b0;
        run   = 1'b0;
        chk("post_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'b0, 1'b0);
        chk_state("post_reset", T0, 9'h000);
        tick();
        chk("post_reset2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'b0, 1'b0);
        tick();

        // Reserved opcode, then back-to-back mv R2,R1
        run = 1'b1;
        din = 16'(9'b101_010_001);
        tick();
        din = 16'(9'b000_010_001);
        chk("rsv_t1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'b0, 1'b1);
        tick();
        chk("b2b_t0", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 10'b0, 1'b0);
        chk_state("b2b_t0", T0, 9'b101_010_001);
        tick();
        run = 1'b0;
        chk("b2b_mv_t1", 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 10'b01_0000_0000, 1'b1);
        tick();
        chk_state("b2b_after", T0, 9'b000_010_001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
